seq_mult_ctrl: RTL and testbench
================================

// Module: seq_mult_ctrl
// PURPOSE
//   Sequential unsigned shift-add multiplier. An FSM sequences one n-bit adder,
//   a cycle counter and operand/accumulator registers.
//   Computes P = A*B over n iterations with a start/busy/done handshake.
//   Sits between control logic and a shared n-bit adder datapath.
// PARAMETERS
//   n     4   operand width in bits (n >= 2); product width is 2n
//   cnt_w 3   iteration counter width; must satisfy 2^cnt_w > n
// PORTS
//   clk    in   1    rising-edge clock; single clock domain
//   r      in   1    reset, asynchronous, active-high
//   start  in   1    request; sampled on clk rising edge while busy=0
//   a      in   n    multiplicand; captured on the accepted start edge
//   b      in   n    multiplier; captured on the accepted start edge
//   busy   out  1    1 while in CALC
//   done   out  1    one-cycle pulse in DONE; p valid
//   p      out  2n   product; held until the next accepted start
// BEHAVIOUR
//   Reset (async, r=1): state=IDLE, busy=0, done=0, p=0, counter=0, regs=0.
//   States:
//     IDLE: wait for start
//     CALC: iterate n times
//     DONE: 1 cycle, then IDLE
//   Transitions:
//     IDLE, start=1 -> CALC: mcand<=a, {hi,lo}<={0,b}, cnt<=0
//     CALC, cnt=n-1 -> DONE; otherwise stay, cnt<=cnt+1
//     DONE, start=1 -> CALC (back-to-back accepted, same capture as IDLE)
//     DONE, start=0 -> IDLE
//   CALC iteration (one per clk):
//     sum[n:0] = lo[0] ? hi+mcand : {1'b0,hi}   (n+1 bits, carry kept)
//     {hi,lo} <= {sum, lo} >> 1                  (2n+1 bit shift, LSB dropped)
//   p <= {hi,lo} on the CALC->DONE edge only; p does not change during CALC.
//   Latency: start sampled at edge E0 -> done=1 and p valid in the cycle
//     after edge E0+n (n CALC cycles, then DONE). Throughput: n+1 cycles/op.
//   busy=1 exactly in CALC; start during CALC is ignored (no queuing);
//     a/b may change freely after the accepting edge.
//   Boundaries:
//     a=0 or b=0 -> p=0, normal latency
//     a=b=2^n-1  -> p=(2^n-1)^2, no overflow (2n bits)
//     cnt wraps only via reload on accept
//   Reset mid-CALC: operation is abandoned immediately; p=0, done never pulses.
// CONFIGURATION
//   SEQ_MULT_ZERO_SKIP_EN defined:
//     in IDLE/DONE, accepted start with a==0 or b==0 -> straight to DONE,
//       p<=0, busy stays 0; latency 1 cycle
//     nonzero operands unchanged
//   Not defined: zero operands take the full n-cycle CALC path
//     (identical result p=0).
// TESTING (n=4)
//   1. Reset: r=1 async mid-cycle -> busy=0, done=0, p=0 immediately,
//      without waiting for a clk edge.
//   2. a=13,b=11, start 1 cycle -> busy high 4 cycles; done pulses once
//      in cycle 5; p=143 and held.
//   3. a=15,b=15 then back-to-back start in DONE with a=3,b=5 -> p=225,
//      then p=15 exactly 5 cycles later.
//   4. a=6,b=7 started; start pulsed again mid-CALC with a=1,b=1
//      -> ignored; p=42.
//   5. a=9,b=9 started, r=1 on CALC cycle 2 -> p=0, no done pulse;
//      then a=2,b=3 -> p=6.
//   6. a=0,b=12 -> p=0; done after 1 cycle if SEQ_MULT_ZERO_SKIP_EN
//      is defined, after 5 cycles otherwise.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
//   Sequential unsigned shift-add multiplier. A three-process FSM sequences
//   one n-bit adder, an iteration counter and operand/accumulator registers
//   to compute p = a*b over n clock cycles with a start/busy/done handshake.
//
// Parameters
//   n      operand width in bits (n >= 2); product width is 2n
//   cnt_w  iteration counter width; 2^cnt_w must exceed n
//
// Ports
//   clk    in   1     rising-edge clock
//   r      in   1     asynchronous active-high reset
//   start  in   1     request, sampled on clk rising edge while busy=0
//   a      in   n     multiplicand, captured on the accepted start edge
//   b      in   n     multiplier, captured on the accepted start edge
//   busy   out  1     high while iterating
//   done   out  1     one-cycle pulse; p valid
//   p      out  2n    product, held until the next accepted start
//
// Optional feature
//   SEQ_MULT_ZERO_SKIP_EN: when defined, an accepted start with a zero
//   operand goes straight to DONE with p=0 (1-cycle latency, busy stays 0).
// ---------------------------------------------------------------------------
module seq_mult_ctrl #(
   parameter int n     = 4,
   parameter int cnt_w = 3
) (
   input  logic           clk,
   input  logic           r,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*n-1:0] p
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [n-1:0]     mcand;
   logic [n-1:0]     hi;
   logic [n-1:0]     lo;
   logic [cnt_w-1:0] cnt;
   logic [n:0]       sum;
   logic             accept;
   logic             skip;
   logic             last_iter;

   // start is only honoured outside CALC; requests during CALC are dropped
   always_comb begin
      accept    = start && ((state == IDLE) || (state == DONE));
      last_iter = (cnt == cnt_w'(n - 1));
`ifdef SEQ_MULT_ZERO_SKIP_EN
      skip      = accept && ((a == '0) || (b == '0));
`else
      skip      = 1'b0;
`endif
      // n+1 bit partial sum keeps the adder carry for the shift
      sum = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
   end

   // state register
   always_ff @(posedge clk or posedge r) begin
      if (r) state <= IDLE;
      else   state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept) state_nxt = skip ? DONE : CALC;
            else        state_nxt = IDLE;
         end
         CALC: begin
            if (last_iter) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      busy = (state == CALC);
      done = (state == DONE);
   end

   // datapath: operand capture, shift-add iteration, product latch
   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         p     <= '0;
      end else if (accept) begin
         mcand <= a;
         hi    <= '0;
         lo    <= b;
         cnt   <= '0;
         if (skip) p <= '0;
      end else if (state == CALC) begin
         // {hi,lo} <= {sum,lo} >> 1
         hi <= sum[n:1];
         lo <= {sum[0], lo[n-1:1]};
         if (last_iter) p   <= {sum, lo[n-1:1]};
         else           cnt <= cnt + cnt_w'(1);
      end
   end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_ctrl
//   Scoreboard bench for seq_mult_ctrl (n=4). The stimulus side predicts,
//   from the handshake rules, which start requests are accepted and on which
//   clock edge each result appears, and queues a*b with that edge. A monitor
//   on the falling edge compares done/p/busy against the queue every cycle.
// ---------------------------------------------------------------------------
module tb_seq_mult_ctrl;

   localparam int N = 4;
`ifdef SEQ_MULT_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic           clk;
   logic           r;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] p;

   seq_mult_ctrl #(.n(N), .cnt_w(3)) dut (
      .clk   (clk),
      .r     (r),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   typedef struct {
      int unsigned prod;
      int          done_e;
   } exp_t;

   exp_t        sbq[$];
   int          edges   = 0;
   int          acc_e   = -10;   // edge of last accepted start
   int          done_e  = -10;   // edge after which done is expected
   int unsigned p_model = 0;
   bit          mon_en  = 0;
   int          tests   = 0;
   int          fails   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edges++;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: runs away from the active edge.
   always @(negedge clk) begin
      if (mon_en && !r) begin
         if (sbq.size() > 0 && sbq[0].done_e == edges) begin
            check("done_pulse", longint'(done), 1);
            check("product", longint'(p), longint'(sbq[0].prod));
            p_model = sbq[0].prod;
            void'(sbq.pop_front());
         end else begin
            check("done_low", longint'(done), 0);
            check("p_held", longint'(p), longint'(p_model));
         end
         check("busy", longint'(busy), longint'(edges >= acc_e && edges < done_e));
      end
   end

   // Drive one cycle of inputs; predicts acceptance on the coming edge.
   task automatic drive(input bit st, input int unsigned av, input int unsigned bv);
      int e;
      bit zero;
      start = st;
      a     = N'(av);
      b     = N'(bv);
      e     = edges + 1;
      zero  = (av % (1 << N) == 0) || (bv % (1 << N) == 0);
      if (st && e > done_e) begin
         acc_e  = e;
         done_e = (SKIP && zero) ? e : e + N;
         sbq.push_back('{prod: (av % (1 << N)) * (bv % (1 << N)), done_e: done_e});
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b0, $urandom, $urandom);
   endtask

   task automatic async_reset();
      r = 1'b1;
      #1;
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_p", longint'(p), 0);
      sbq.delete();
      p_model = 0;
      acc_e   = -10;
      done_e  = -10;
      #1;
      r = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      r = 1'b1; start = 1'b0; a = '0; b = '0;
      #1;
      check("init_busy", longint'(busy), 0);
      check("init_done", longint'(done), 0);
      check("init_p", longint'(p), 0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      r = 1'b0;
      mon_en = 1'b1;

      // basic product
      drive(1'b1, 13, 11);
      idle(7);
      // max operands, then back-to-back start in DONE
      drive(1'b1, 15, 15);
      idle(4);
      drive(1'b1, 3, 5);
      idle(6);
      // start during CALC is ignored
      drive(1'b1, 6, 7);
      idle(1);
      drive(1'b1, 1, 1);
      idle(6);
      // reset mid-CALC abandons the operation
      drive(1'b1, 9, 9);
      idle(1);
      async_reset();
      idle(2);
      drive(1'b1, 2, 3);
      idle(6);
      // zero operands
      drive(1'b1, 0, 12);
      idle(6);
      drive(1'b1, 7, 0);
      idle(1);
      drive(1'b1, 5, 5);
      idle(6);

      // random traffic, including starts that land during CALC
      for (int i = 0; i < 400; i++) begin
         int unsigned av, bv;
         av = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
         bv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
         drive($urandom_range(0, 2) == 0, av, bv);
      end
      idle(N + 3);

      check("queue_drained", longint'(sbq.size()), 0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
